// File: rtl/obi_wishbone_bridge_if.sv
// obi_wishbone_bridge_if
//
// Bundles both sides of the OBI-to-Wishbone bridge into one interface:
// the core-facing OBI request/grant/rvalid port and the Wishbone classic
// master port.
//
// Modports:
//   slave  - the bridge's view. It is the OBI slave of the core and drives
//            gnt/rvalid/rdata/err plus every wb_* master output.
//   master - the environment's view: the core issuing OBI requests together
//            with the Wishbone slave returning data/ack/err.
//
// Signals (names keep the bridge-side direction suffixes):
//   req_i, addr_i, we_i, be_i, wdata_i   OBI request from the core
//   gnt_o                                OBI grant (combinational)
//   rvalid_o, rdata_o, err_o             OBI response, qualified by rvalid_o
//   wb_cyc_o, wb_stb_o, wb_we_o,
//   wb_addr_o, wb_sel_o, wb_data_o       Wishbone master outputs
//   wb_data_i, wb_ack_i, wb_err_i        Wishbone slave response
interface obi_wishbone_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   logic                  req_i;
   logic                  gnt_o;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic                  we_i;
   logic [SEL_WIDTH-1:0]  be_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  rvalid_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  err_o;

   logic                  wb_cyc_o;
   logic                  wb_stb_o;
   logic                  wb_we_o;
   logic [ADDR_WIDTH-1:0] wb_addr_o;
   logic [SEL_WIDTH-1:0]  wb_sel_o;
   logic [DATA_WIDTH-1:0] wb_data_o;
   logic [DATA_WIDTH-1:0] wb_data_i;
   logic                  wb_ack_i;
   logic                  wb_err_i;

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i,
      input  wb_data_i, wb_ack_i, wb_err_i,
      output gnt_o, rvalid_o, rdata_o, err_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o
   );

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i,
      output wb_data_i, wb_ack_i, wb_err_i,
      input  gnt_o, rvalid_o, rdata_o, err_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_data_o
   );

endinterface

// File: rtl/obi_wishbone_bridge.sv
// obi_wishbone_bridge
//
// Turns the core's OBI request/grant/rvalid memory port into a Wishbone
// classic master with exactly one transaction in flight. Every accepted
// request, read or write, gets a single-cycle rvalid response. A bus cycle
// that sees neither ack nor err for TIMEOUT_CYCLES cycles is ended locally
// and reported to the core as an error.
//
// Parameters:
//   ADDR_WIDTH      address width on both sides
//   DATA_WIDTH      data width; byte selects are DATA_WIDTH/8 wide
//   TIMEOUT_CYCLES  cycles to wait for ack/err before giving up (0 = never)
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    obi_wishbone_bridge_if.slave (OBI port + Wishbone master port)
module obi_wishbone_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   obi_wishbone_bridge_if.slave   bus
);

   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   // The counter only has to reach TIMEOUT_CYCLES-1, but it is sized for
   // TIMEOUT_CYCLES so the saturation point never sits on the threshold.
   localparam int CNT_WIDTH = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned THRESH_INT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CNT_WIDTH-1:0] THRESH  = CNT_WIDTH'(THRESH_INT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                state;
   logic [CNT_WIDTH-1:0]  wait_cnt;

   logic                  wb_cyc_q;
   logic                  wb_we_q;
   logic [ADDR_WIDTH-1:0] wb_addr_q;
   logic [SEL_WIDTH-1:0]  wb_sel_q;
   logic [DATA_WIDTH-1:0] wb_data_q;
   logic                  rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic                  can_accept;
   logic                  accept;
   logic                  bus_done;
   logic                  timeout_hit;

   // A new request can be taken whenever no Wishbone cycle is running. That
   // includes RESP, which is what lets a zero-wait slave sustain one request
   // every two cycles. The grant is purely combinational on req_i.
   assign can_accept  = (state == IDLE) || (state == RESP);
   assign accept      = can_accept && bus.req_i;
   assign bus_done    = bus.wb_ack_i || bus.wb_err_i;
   assign timeout_hit = TIMEOUT_EN && (wait_cnt == THRESH);

   assign bus.gnt_o     = accept;
   assign bus.wb_cyc_o  = wb_cyc_q;
   assign bus.wb_stb_o  = wb_cyc_q;
   assign bus.wb_we_o   = wb_we_q;
   assign bus.wb_addr_o = wb_addr_q;
   assign bus.wb_sel_o  = wb_sel_q;
   assign bus.wb_data_o = wb_data_q;
   assign bus.rvalid_o  = rvalid_q;
   assign bus.rdata_o   = rdata_q;
   assign bus.err_o     = err_q;

   // Single state machine holding every registered output.
   // The request fields are captured straight into the Wishbone output
   // registers at acceptance and then left alone until the next acceptance.
   // In BUS an ack or err finishes the cycle. err takes priority over ack,
   // and an ack in the same cycle as the timeout threshold still counts as
   // a normal completion. rdata is only loaded for an error-free read; any
   // other response returns zero. rvalid is raised on the way into RESP,
   // so it is high for exactly the one cycle spent there. rdata/err keep
   // their last value afterwards. The wait counter saturates and never
   // wraps, which keeps a disabled timeout (TIMEOUT_CYCLES = 0) harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         wb_cyc_q  <= 1'b0;
         wb_we_q   <= 1'b0;
         wb_addr_q <= '0;
         wb_sel_q  <= '0;
         wb_data_q <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  wb_cyc_q  <= 1'b1;
                  wb_we_q   <= bus.we_i;
                  wb_addr_q <= bus.addr_i;
                  wb_sel_q  <= bus.be_i;
                  wb_data_q <= bus.wdata_i;
                  wait_cnt  <= '0;
                  state     <= BUS;
               end else begin
                  state <= IDLE;
               end
            end
            BUS: begin
               if (bus_done) begin
                  wb_cyc_q <= 1'b0;
                  rvalid_q <= 1'b1;
                  err_q    <= bus.wb_err_i;
                  if (!wb_we_q && !bus.wb_err_i) begin
                     rdata_q <= bus.wb_data_i;
                  end else begin
                     rdata_q <= '0;
                  end
                  state <= RESP;
               end else if (timeout_hit) begin
                  wb_cyc_q <= 1'b0;
                  rvalid_q <= 1'b1;
                  err_q    <= 1'b1;
                  rdata_q  <= '0;
                  state    <= RESP;
               end else if (wait_cnt != CNT_MAX) begin
                  wait_cnt <= wait_cnt + CNT_WIDTH'(1);
               end
            end
            default: begin
               wb_cyc_q <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
